// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types: FSM states, IF/ID payload, reset defaults and PC increment.
// No logic or latency of its own; used by every fetch_stage file.
package fetch_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP      = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/ack port: req is a level held until ack; addr is stable while req=1.
// The ack is a single-cycle pulse that may land in the first req cycle; rdata is valid only with ack.
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID register: 1-cycle register, priority is reset > clear (bubble) > enable.
// While en=0 and clr=0 it holds, which is how decode backpressure freezes the word.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP = DEF_NOP
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    input  logic  clr,
    input  ifid_t d,
    output ifid_t q
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q.instr    <= NOP;
            q.pc_plus4 <= 32'd0;
            q.valid    <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, one-outstanding-request fetch FSM and a one-word buffer; ack in cycle N shows in ID at N+1.
// StallIF parks a fetched word in the buffer (HOLD), StallID freezes IF/ID; redirects flush and drop stale replies.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP      = DEF_NOP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StallIF,
    input  logic               StallID,
    input  logic               PCSrcD,
    input  logic [31:0]        PCBranchD,
    input  logic               JumpD,
    input  logic [31:0]        PCJumpD,
    fetch_stage_if.master      imem,
    output logic [31:0]        InstrD,
    output logic [31:0]        PCPlus4D,
    output logic               ValidD
);

    fetch_state_t state;
    logic [31:0]  pcf;
    logic [31:0]  addr_q;
    logic [31:0]  buf_word;

    logic         redirect;
    logic [31:0]  target;
    logic         got_ack;
    logic         word_avail;
    logic [31:0]  word;
    logic         advance;
    logic         ifid_en;
    logic         ifid_clr;
    ifid_t        ifid_d;
    ifid_t        ifid_q;

    always_comb begin
        redirect   = (PCSrcD | JumpD) & ValidD & ~StallID;
        target     = PCSrcD ? PCBranchD : PCJumpD;
        got_ack    = (state == ST_REQ) & imem.ack;
        word_avail = got_ack | (state == ST_HOLD);
        word       = (state == ST_HOLD) ? buf_word : imem.rdata;
        advance    = ~redirect & word_avail & ~StallIF;
        // A stalled-IF cycle with decode free still hands decode a bubble.
        ifid_en    = advance & ~StallID;
        ifid_clr   = redirect | (~StallID & ~advance);
        ifid_d     = '{instr: word, pc_plus4: pc_next(pcf), valid: 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_REQ;
            pcf      <= RESET_PC;
            addr_q   <= RESET_PC;
            buf_word <= '0;
        end else if (redirect) begin
            pcf <= target;
            case (state)
                ST_REQ: begin
                    if (imem.ack) begin
                        addr_q <= target;
                    end else begin
                        state <= ST_DROP;
                    end
                end
                ST_HOLD: begin
                    state  <= ST_REQ;
                    addr_q <= target;
                end
                ST_DROP: begin
                    // The stale reply may land in the same cycle as the redirect.
                    if (imem.ack) begin
                        state  <= ST_REQ;
                        addr_q <= target;
                    end
                end
                default: begin
                    state  <= ST_REQ;
                    addr_q <= target;
                end
            endcase
        end else begin
            case (state)
                ST_REQ: begin
                    if (imem.ack) begin
                        if (!StallIF) begin
                            pcf    <= pc_next(pcf);
                            addr_q <= pc_next(pcf);
                        end else begin
                            buf_word <= imem.rdata;
                            state    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!StallIF) begin
                        pcf    <= pc_next(pcf);
                        addr_q <= pc_next(pcf);
                        state  <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem.ack) begin
                        state  <= ST_REQ;
                        addr_q <= pcf;
                    end
                end
                default: begin
                    state  <= ST_REQ;
                    addr_q <= pcf;
                end
            endcase
        end
    end

    assign imem.req  = ~reset & (state != ST_HOLD);
    assign imem.addr = addr_q;

    fetch_stage_if_id_reg #(.NOP(NOP)) u_if_id (
        .clk   (clk),
        .reset (reset),
        .en    (ifid_en),
        .clr   (ifid_clr),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign InstrD   = ifid_q.instr;
    assign PCPlus4D = ifid_q.pc_plus4;
    assign ValidD   = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios, then randomized stalls/redirects/latency checked
// against an in-order program-stream model (expected PC sequence plus word-from-address memory).
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_W  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallIF, StallID, PCSrcD, JumpD;
    logic [31:0] PCBranchD, PCJumpD;
    logic [31:0] InstrD, PCPlus4D;
    logic        ValidD;

    fetch_stage_if imem ();

    fetch_stage #(.RESET_PC(RST_PC), .NOP(NOP_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .StallIF   (StallIF),
        .StallID   (StallID),
        .PCSrcD    (PCSrcD),
        .PCBranchD (PCBranchD),
        .JumpD     (JumpD),
        .PCJumpD   (PCJumpD),
        .imem      (imem),
        .InstrD    (InstrD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    // Memory slave: latency chosen per request (fixed or random 0..3), one outstanding request.
    int          lat_mode  = 0;
    int          wait_cnt  = -1;
    logic [31:0] hold_addr = '0;

    initial begin
        imem.ack   = 1'b0;
        imem.rdata = '0;
    end

    always @(posedge clk) begin
        #2;
        if (wait_cnt >= 0 && imem.req)
            chk("addr_stable", imem.addr, hold_addr);
        if (wait_cnt < 0 && imem.req) begin
            wait_cnt  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            hold_addr = imem.addr;
        end
        if (wait_cnt == 0) begin
            imem.ack   = 1'b1;
            imem.rdata = mem_word(hold_addr);
            wait_cnt   = -1;
        end else begin
            imem.ack   = 1'b0;
            imem.rdata = 32'hDEAD_BEEF;
            if (wait_cnt > 0) wait_cnt--;
        end
        if (reset) wait_cnt = -1;
    end

    // Program-stream model: each newly delivered instruction must be the next one in program order.
    logic [31:0] exp_pc     = RST_PC;
    int          deliveries = 0;
    logic        p_reset    = 1'b1;
    logic        p_redir    = 1'b0;
    logic        p_stallid  = 1'b0;
    logic [31:0] p_target   = '0;
    logic [31:0] p_instr    = '0;
    logic [31:0] p_pc4      = '0;
    logic        p_valid    = 1'b0;

    always @(negedge clk) begin
        if (p_reset) begin
            chk("rst_valid", ValidD, 1'b0);
            chk("rst_instr", InstrD, NOP_W);
            chk("rst_pc4", PCPlus4D, 32'd0);
            exp_pc = RST_PC;
        end else if (p_redir) begin
            chk("flush_valid", ValidD, 1'b0);
            chk("flush_instr", InstrD, NOP_W);
            exp_pc = p_target;
        end else if (p_stallid) begin
            chk("hold_instr", InstrD, p_instr);
            chk("hold_pc4", PCPlus4D, p_pc4);
            chk("hold_valid", ValidD, p_valid);
        end else if (ValidD) begin
            chk("seq_pc", PCPlus4D - 32'd4, exp_pc);
            chk("seq_instr", InstrD, mem_word(PCPlus4D - 32'd4));
            exp_pc = PCPlus4D;
            deliveries++;
        end else begin
            chk("bubble_instr", InstrD, NOP_W);
            chk("bubble_pc4", PCPlus4D, 32'd0);
        end
        p_reset   = reset;
        p_redir   = (PCSrcD | JumpD) & ValidD & ~StallID;
        p_stallid = StallID;
        p_target  = PCSrcD ? PCBranchD : PCJumpD;
        p_instr   = InstrD;
        p_pc4     = PCPlus4D;
        p_valid   = ValidD;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc4,
                           input logic r, input logic [31:0] a);
        chk({tag, "_valid"}, ValidD, v);
        chk({tag, "_pc4"}, PCPlus4D, pc4);
        chk({tag, "_req"}, imem.req, r);
        if (r) chk({tag, "_addr"}, imem.addr, a);
    endtask

    initial begin
        reset = 1'b1; StallIF = 1'b0; StallID = 1'b0;
        PCSrcD = 1'b0; JumpD = 1'b0; PCBranchD = '0; PCJumpD = '0;
        lat_mode = 0;

        tick();
        chk("req_in_reset", imem.req, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        chk_out("c0", 1'b0, 32'd0, 1'b1, RST_PC);

        // Zero-wait memory: one instruction per cycle.
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk_out("zw", 1'b1, 32'(4 * k), 1'b1, 32'(4 * k));
            chk("zw_instr", InstrD, mem_word(32'(4 * (k - 1))));
        end

        // Branch while the 0x20 request is outstanding.
        lat_mode = 3; PCSrcD = 1'b1; PCBranchD = 32'h100;
        tick();
        chk_out("drop", 1'b0, 32'd0, 1'b1, 32'h20);
        PCSrcD = 1'b0;
        tick();
        chk_out("drop2", 1'b0, 32'd0, 1'b1, 32'h20);
        tick();
        tick();
        chk_out("redir", 1'b0, 32'd0, 1'b1, 32'h100);

        // Slow memory: bubbles until the ack, PC advances once.
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out("slow", 1'b0, 32'd0, 1'b1, 32'h100);
        end
        lat_mode = 0;
        tick();
        chk_out("slow_done", 1'b1, 32'h104, 1'b1, 32'h104);
        chk("slow_instr", InstrD, mem_word(32'h100));

        // Both stalls while the word arrives: HOLD with req low, IF/ID frozen.
        StallIF = 1'b1; StallID = 1'b1;
        tick();
        chk_out("hold1", 1'b1, 32'h104, 1'b0, 32'h0);
        tick();
        chk_out("hold2", 1'b1, 32'h104, 1'b0, 32'h0);
        StallIF = 1'b0; StallID = 1'b0;
        tick();
        chk_out("release", 1'b1, 32'h108, 1'b1, 32'h108);
        chk("release_instr", InstrD, mem_word(32'h104));

        // Branch under StallID is ignored, then taken once decode is free.
        PCSrcD = 1'b1; PCBranchD = 32'h200; StallIF = 1'b1; StallID = 1'b1;
        tick();
        chk_out("br_stalled", 1'b1, 32'h108, 1'b0, 32'h0);
        StallIF = 1'b0; StallID = 1'b0;
        tick();
        chk_out("br_taken", 1'b0, 32'd0, 1'b1, 32'h200);
        PCSrcD = 1'b0;
        tick();
        chk_out("br_first", 1'b1, 32'h204, 1'b1, 32'h204);

        // Jump into DROP, then reset in the cycle the stale ack returns.
        lat_mode = 3; JumpD = 1'b1; PCJumpD = 32'h300;
        tick();
        chk_out("j_drop", 1'b0, 32'd0, 1'b1, 32'h204);
        JumpD = 1'b0;
        tick();
        tick();
        chk("j_drop_addr", imem.addr, 32'h204);
        reset = 1'b1;
        tick();
        chk("rst_drop_valid", ValidD, 1'b0);
        chk("rst_drop_instr", InstrD, NOP_W);
        reset = 1'b0; lat_mode = 0;
        tick();
        chk_out("after_rst", 1'b1, RST_PC + 32'd4, 1'b1, RST_PC + 32'd4);
        chk("after_rst_instr", InstrD, mem_word(RST_PC));

        // Randomized traffic; StallID only together with StallIF, as the hazard unit does.
        lat_mode = -1;
        repeat (3000) begin
            tick();
            reset     = ($urandom_range(0, 199) == 0);
            StallIF   = ($urandom_range(0, 99) < 20);
            StallID   = StallIF && ($urandom_range(0, 1) == 1);
            PCSrcD    = ($urandom_range(0, 99) < 10);
            JumpD     = ($urandom_range(0, 99) < 8);
            PCBranchD = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
            PCJumpD   = $urandom;
        end
        reset = 1'b0; StallIF = 1'b0; StallID = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
        repeat (10) tick();
        chk("liveness", 32'(deliveries > 300), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
